// File: rtl/fetch_pkg.sv
// Shared constants and payload type for the instruction fetch path.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: registered FIFO of {pc, instr} entries with flush and occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  fetch_entry_t             i_push_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output fetch_entry_t             o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_entry_t    r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];

   // A push into a full buffer is legal only when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; stale contents are never visible while empty.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers responses with their PC,
// and handles core redirects by flushing and discarding responses to pre-redirect requests.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req_valid,
   input  logic         imem_req_ready,
   output logic [31:0]  imem_req_addr,
   input  logic         imem_rsp_valid,
   input  logic [31:0]  imem_rsp_data,
   output logic         instr_valid,
   input  logic         instr_ready,
   output logic [31:0]  instr,
   output logic [31:0]  instr_pc,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc
);

   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   logic [31:0]    r_fetch_pc;
   logic [31:0]    r_rsp_pc;
   logic [CW-1:0]  r_outstanding;
   logic [CW-1:0]  r_drop_cnt;

   logic [CW-1:0]  w_count;
   logic [CW:0]    w_inflight;
   logic           w_accept;
   logic           w_drop;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   fetch_entry_t   w_push_data;
   fetch_entry_t   w_head;

   // Every in-flight request already owns a buffer slot, so the buffer can never overflow.
   assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
   assign imem_req_valid = !rst && !redirect_valid && !w_full && (w_inflight < LIMIT);
   assign imem_req_addr  = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   assign w_drop         = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
   assign w_push         = imem_rsp_valid && !w_drop;
   assign w_pop          = instr_valid && instr_ready && !redirect_valid;

   assign w_push_data.pc    = r_rsp_pc;
   assign w_push_data.instr = imem_rsp_data;

   assign instr_valid = !w_empty;
   assign instr       = instr_valid ? w_head.instr : NOP_INSTR;
   assign instr_pc    = instr_valid ? w_head.pc : 32'h0000_0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= align_word(RESET_PC);
         r_rsp_pc      <= align_word(RESET_PC);
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         case ({w_accept, imem_rsp_valid})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase

         // Responses return in order, so the next kept response always belongs to r_rsp_pc.
         if (redirect_valid) begin
            r_fetch_pc <= align_word(redirect_pc);
            r_rsp_pc   <= align_word(redirect_pc);
            r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_drop) begin
               r_drop_cnt <= r_drop_cnt - CW'(1);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count),
      .o_head      (w_head)
   );

endmodule
